// File: rtl/motor_pulse_driver_pkg.sv
// Shared types and constants for the motor pulse driver slice.
package Motor_PKG;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    FIN
  } motor_state_t;

  localparam int unsigned MOTOR_T_HIGH   = 2;
  localparam int unsigned MOTOR_T_PERIOD = 4;

  // Level driven on dir_* when the requested count is negative.
  localparam logic MOTOR_DIR_NEG = 1'b1;

endpackage

// File: rtl/motor_pulse_driver_axis.sv
// Single-axis step generator: emits `count` pulses of T_HIGH high /
// (T_PERIOD-T_HIGH) low, starting the cycle after `start`.
module motor_axis_pulser #(
  parameter int unsigned CNT_BITS = 8,
  parameter int unsigned T_HIGH   = 2,
  parameter int unsigned T_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_BITS-1:0] count,
  output logic                step,
  output logic                finished
);

  localparam int unsigned TW = $clog2(T_PERIOD);
  localparam logic [TW-1:0] LP_HIGH = TW'(T_HIGH);
  localparam logic [TW-1:0] LP_LAST = TW'(T_PERIOD - 1);

  logic                r_active;
  logic [CNT_BITS-1:0] r_left;
  logic [TW-1:0]       r_tmr;
  logic                w_last_cycle;
  logic                w_last_pulse;

  assign w_last_cycle = (r_tmr == LP_LAST);
  assign w_last_pulse = (r_left == CNT_BITS'(1));

  // Pulse/phase counters: load on start, count down whole periods, stop at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_left   <= '0;
      r_tmr    <= '0;
    end else if (start) begin
      r_active <= (count != '0);
      r_left   <= count;
      r_tmr    <= '0;
    end else if (r_active) begin
      if (w_last_cycle) begin
        r_tmr  <= '0;
        r_left <= r_left - 1'b1;
        if (w_last_pulse) begin
          r_active <= 1'b0;
        end
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign step = r_active && (r_tmr < LP_HIGH);

  // Reported during the final low cycle so the controller can leave RUN on
  // the same edge that ends the last period.
  assign finished = !r_active || (w_last_pulse && w_last_cycle);

endmodule

// File: rtl/motor_pulse_driver.sv
// Two-axis step/dir driver: accepts one signed X/Y movement per handshake,
// runs both axes concurrently, pulses done when the later axis completes.
module motor_pulse_driver
  import Motor_PKG::*;
#(
  parameter int unsigned PULSE_NUM_X_BITS = 8,
  parameter int unsigned PULSE_NUM_Y_BITS = 8,
  parameter int unsigned T_HIGH           = MOTOR_T_HIGH,
  parameter int unsigned T_PERIOD         = MOTOR_T_PERIOD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic [PULSE_NUM_X_BITS-1:0] pulse_num_x,
  input  logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
  output logic                        rdy,
  output logic                        done,
  output logic                        step_x,
  output logic                        dir_x,
  output logic                        step_y,
  output logic                        dir_y
);

  motor_state_t r_state;
  motor_state_t w_next;

  logic [PULSE_NUM_X_BITS-1:0] r_mag_x;
  logic [PULSE_NUM_Y_BITS-1:0] r_mag_y;
  logic                        r_dir_x;
  logic                        r_dir_y;
  logic                        w_neg_x;
  logic                        w_neg_y;
  logic                        w_accept;
  logic                        w_start;
  logic                        w_fin_x;
  logic                        w_fin_y;

  assign w_neg_x  = pulse_num_x[PULSE_NUM_X_BITS-1];
  assign w_neg_y  = pulse_num_y[PULSE_NUM_Y_BITS-1];
  assign w_accept = (r_state == IDLE) && trigger;
  assign w_start  = (r_state == SETUP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch magnitudes and directions on the accepting edge so dir is already
  // valid throughout SETUP and holds until the next accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag_x <= '0;
      r_mag_y <= '0;
      r_dir_x <= ~MOTOR_DIR_NEG;
      r_dir_y <= ~MOTOR_DIR_NEG;
    end else if (w_accept) begin
      r_mag_x <= w_neg_x ? ('0 - pulse_num_x) : pulse_num_x;
      r_mag_y <= w_neg_y ? ('0 - pulse_num_y) : pulse_num_y;
      r_dir_x <= w_neg_x ? MOTOR_DIR_NEG : ~MOTOR_DIR_NEG;
      r_dir_y <= w_neg_y ? MOTOR_DIR_NEG : ~MOTOR_DIR_NEG;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (trigger) w_next = SETUP;
      SETUP: w_next = ((r_mag_x == '0) && (r_mag_y == '0)) ? FIN : RUN;
      RUN:   if (w_fin_x && w_fin_y) w_next = FIN;
      FIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign rdy   = (r_state == IDLE);
  assign done  = (r_state == FIN);
  assign dir_x = r_dir_x;
  assign dir_y = r_dir_y;

  motor_axis_pulser #(
    .CNT_BITS (PULSE_NUM_X_BITS),
    .T_HIGH   (T_HIGH),
    .T_PERIOD (T_PERIOD)
  ) u_axis_x (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .count    (r_mag_x),
    .step     (step_x),
    .finished (w_fin_x)
  );

  motor_axis_pulser #(
    .CNT_BITS (PULSE_NUM_Y_BITS),
    .T_HIGH   (T_HIGH),
    .T_PERIOD (T_PERIOD)
  ) u_axis_y (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .count    (r_mag_y),
    .step     (step_y),
    .finished (w_fin_y)
  );

endmodule

// File: doc/motor_pulse_driver.md
Name: motor_pulse_driver

Overview:
- Consumes the signed per-movement pulse counts (X and Y) produced by the op handlers and turns them into step/dir waveforms for two stepper-motor drivers.
- Accepts one movement per trigger/ready handshake, runs both axes concurrently at a fixed step rate, and pulses done when both axes finish.
- Sits between the processor op handlers and the physical motor pins.

Parameters:
- PULSE_NUM_X_BITS, 8, width of signed X pulse count (two's complement).
- PULSE_NUM_Y_BITS, 8, width of signed Y pulse count (two's complement).
- T_HIGH, 2, step high time in clk cycles; must be >= 1.
- T_PERIOD, 4, full step period in clk cycles; must be > T_HIGH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  start request; sampled only while rdy=1.
- pulse_num_x  in  PULSE_NUM_X_BITS  signed X pulse count; sampled with trigger.
- pulse_num_y  in  PULSE_NUM_Y_BITS  signed Y pulse count; sampled with trigger.
- rdy  out  1  block idle; a trigger is accepted this cycle.
- done  out  1  one-cycle pulse when the movement completes.
- step_x  out  1  X step pulse.
- dir_x  out  1  X direction; 1 = negative.
- step_y  out  1  Y step pulse.
- dir_y  out  1  Y direction; 1 = negative.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: rdy=1, done=0, step_x=0, step_y=0, dir_x=0, dir_y=0. FSM returns to IDLE.
- Reset mid-run aborts immediately. Step outputs go low on the next edge and remaining counts are discarded.
- FSM states and transitions:
  - IDLE: rdy=1. On trigger, latch magnitudes and signs, go to SETUP.
  - SETUP: one cycle. dir_x and dir_y are driven from the latched signs. Both axis pulsers start. Go to RUN; go straight to FIN if both magnitudes are 0.
  - RUN: wait until both pulsers report finished, then go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- rdy=0 in every state except IDLE. A trigger while rdy=0 is ignored and not queued.
- Magnitude is |pulse_num| computed in the full N bits, treated as unsigned. The most negative value is legal: -128 with N=8 gives 128 pulses.
- Zero count on an axis: that axis emits no pulse and is finished immediately. Its dir still reflects the sign bit (0).
- Per-axis pulse timing:
  - First rising edge of step occurs in the cycle after SETUP, so trigger at edge k gives step high at k+2.
  - step is high T_HIGH cycles, then low T_PERIOD-T_HIGH cycles.
  - The axis is finished after the low phase of its last pulse completes.
- Axes are independent. The shorter axis idles low while the longer one continues. done follows the later axis.
- Dir hold: dir_x and dir_y change only in SETUP and hold through RUN, FIN and IDLE until the next accepted trigger. This guarantees dir setup >= 1 cycle before the first step edge and hold after the last.
- Counter widths: pulse counter N bits unsigned; timing counter $clog2(T_PERIOD) bits. No wrap is possible, because the counter decrements to 0 and stops.
- Total movement latency = 2 + max(|x|,|y|)*T_PERIOD cycles from the trigger edge to the done cycle (FIN).

Decomposition:
- Shared package Motor_PKG holds:
  - The FSM state enum: IDLE, SETUP, RUN, FIN.
  - The default T_HIGH / T_PERIOD constants.
  - The dir polarity constant MOTOR_DIR_NEG = 1.
- One sub-module, motor_axis_pulser, parameterised by count width, T_HIGH and T_PERIOD, instantiated twice (X and Y).
  - Inputs: clk, reset, start, count.
  - Outputs: step, finished.

Test Plan:
- Trigger with x=3, y=0 (defaults) -> dir_x=0; exactly 3 step_x pulses, each 2 high / 2 low, first high 2 cycles after the trigger edge; step_y stays 0; done at cycle 14; rdy back at 15.
- Trigger with x=-2, y=5 -> dir_x=1, dir_y=0 from SETUP; 2 X pulses and 5 Y pulses run concurrently; step_x idle after pulse 2; done at cycle 22.
- Trigger with x=0, y=0 -> no step pulses; done exactly 2 cycles after the trigger edge; rdy=1 the next cycle.
- Trigger with x=-128, y=127 (N=8) -> 128 X pulses with dir_x=1 and 127 Y pulses; done after 2+128*4 = 514 cycles.
- Trigger held high during RUN with different counts -> ignored; pulse totals match the first request; the second request is accepted only when rdy=1.
- Assert reset after the 2nd of 4 X pulses -> step_x low on the next edge; rdy=1, done never asserted; a new trigger with x=1 runs normally.
